// File: rtl/seq_counter_fsm.sv
// Timing-step generator: IDLE/RUN/HALT control with a 3-bit step counter feeding the step decoder.
// Optional single-step mode is compiled in when SEQ_SINGLE_STEP_EN is defined.
module seq_counter_fsm #(
    parameter int unsigned LAST_STEP = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt_req,
    input  logic       clr,
    input  logic       stall,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step_pulse,
`endif
    output logic [2:0] seq_out,
    output logic       running,
    output logic       halted,
    output logic       wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [2:0] LP_LAST = 3'(LAST_STEP);

    state_t     r_state;
    state_t     w_state_nx;
    logic [2:0] r_seq;
    logic [2:0] w_seq_nx;
    logic       r_halt_pend;
    logic       w_pend_nx;
    logic       r_wrap;
    logic       w_wrap_nx;
    logic       w_boundary;
    logic       w_stall;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_stall = stall | (step_mode & ~step_pulse);
`else
    assign w_stall = stall;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_seq       <= '0;
            r_halt_pend <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_seq       <= w_seq_nx;
            r_halt_pend <= w_pend_nx;
            r_wrap      <= w_wrap_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_seq_nx   = r_seq;
        w_pend_nx  = r_halt_pend;
        w_wrap_nx  = 1'b0;
        w_boundary = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                w_seq_nx  = '0;
                w_pend_nx = 1'b0;
                if (start) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                w_pend_nx = r_halt_pend | halt_req;
                if (clr) begin
                    w_seq_nx   = '0;
                    w_boundary = 1'b1;
                end else if (!w_stall) begin
                    // >= keeps the count bounded even if LAST_STEP shrinks below a stale value
                    if (r_seq >= LP_LAST) begin
                        w_seq_nx   = '0;
                        w_wrap_nx  = 1'b1;
                        w_boundary = 1'b1;
                    end else begin
                        w_seq_nx = r_seq + 3'd1;
                    end
                end
                if (w_boundary && w_pend_nx) begin
                    w_state_nx = S_HALT;
                    w_seq_nx   = '0;
                    w_pend_nx  = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_seq_nx   = '0;
                w_pend_nx  = 1'b0;
            end
        endcase
    end

    assign seq_out = r_seq;
    assign running = (r_state == S_RUN);
    assign halted  = (r_state == S_HALT);
    assign wrap    = r_wrap;

endmodule
